// File: rtl/stim_seq_pkg.sv
// Shared types and constants for the stimulus sequencer.
// Word layout: bit OBS_BIT is the observation flag, the rest is data.
package stim_seq_pkg;

    localparam int WORD_W  = 32;
    localparam int DATA_W  = 31;
    localparam int OBS_BIT = 31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

endpackage

// File: rtl/stim_seq_buf.sv
// Stimulus register file: sequential write at the fill index,
// combinational read at the run pointer. Contents are never reset.
module stim_seq_buf
    import stim_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_idx,
    output logic [WORD_W-1:0] rd_data,
    output logic [AW:0]       fill
);

    localparam logic [AW:0] F_ONE = {{AW{1'b0}}, 1'b1};

    logic [WORD_W-1:0] mem [DEPTH];

    // Entry storage; a clear in the same cycle discards the write.
    always_ff @(posedge clock) begin
        if (wr_en && !clear)
            mem[fill[AW-1:0]] <= wr_data;
    end

    // Fill counter tracks how many entries hold valid stimulus.
    always_ff @(posedge clock) begin
        if (reset || clear)
            fill <= '0;
        else if (wr_en)
            fill <= fill + F_ONE;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/stim_seq.sv
// Stimulus sequencer: buffers host words and plays them out to a DUT.
// Define STIM_SEQ_LOOP_EN to honour loop_en; otherwise runs always end.
module stim_seq
    import stim_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load_valid,
    input  logic [WORD_W-1:0]        load_data,
    output logic                     load_ready,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     step,
    input  logic                     loop_en,
    output logic [DATA_W-1:0]        datai,
    output logic                     obs,
    output logic                     issue,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic [CNT_W-1:0]         issued_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]    P_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      F_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef STIM_SEQ_LOOP_EN
    localparam logic LOOP_CFG = 1'b1;
`else
    localparam logic LOOP_CFG = 1'b0;
`endif

    state_t            state;
    state_t            state_nx;
    logic [AW:0]       fill;
    logic [WORD_W-1:0] entry;
    logic              wr_en;
    logic              loop_eff;
    logic              last;
    logic              launch;
    logic              do_issue;

    assign loop_eff = loop_en & LOOP_CFG;
    assign last     = ({1'b0, pc} == (fill - F_ONE));
    assign wr_en    = load_valid && load_ready && !clear;
    assign launch   = !clear && start && (fill != '0)
                    && (state == S_IDLE || state == S_DONE);
    assign do_issue = !clear
                    && ((state == S_RUN && !stop)
                     || (state == S_PAUSE && step));

    stim_seq_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_data (load_data),
        .rd_idx  (pc),
        .rd_data (entry),
        .fill    (fill)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state: clear first, then stop over start, step over start.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (launch)
                        state_nx = S_RUN;
                end
                S_RUN: begin
                    if (stop)
                        state_nx = S_PAUSE;
                    else if (last && !loop_eff)
                        state_nx = S_DONE;
                end
                S_PAUSE: begin
                    if (step)
                        state_nx = (last && !loop_eff) ? S_DONE : S_PAUSE;
                    else if (start)
                        state_nx = S_RUN;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // State-decoded status outputs.
    always_comb begin
        busy       = (state == S_RUN) || (state == S_PAUSE);
        done       = (state == S_DONE);
        load_ready = (state == S_IDLE) && !fill[AW];
    end

    // Issue datapath: output word, run pointer and saturating counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            datai      <= '0;
            obs        <= 1'b0;
            issue      <= 1'b0;
            pc         <= '0;
            issued_cnt <= '0;
        end else begin
            issue <= do_issue;
            if (clear) begin
                pc <= '0;
            end else if (launch) begin
                pc         <= '0;
                issued_cnt <= '0;
            end else if (do_issue) begin
                datai <= entry[DATA_W-1:0];
                obs   <= entry[OBS_BIT];
                pc    <= last ? '0 : pc + P_ONE;
                if (issued_cnt != '1)
                    issued_cnt <= issued_cnt + C_ONE;
            end
        end
    end

endmodule

// File: tb/tb_stim_seq.sv
// Directed self-checking bench for stim_seq (DEPTH=8, CNT_W=16).
// The loop scenario adapts to whether STIM_SEQ_LOOP_EN is defined.
module tb_stim_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        clear;
    logic        start;
    logic        stop;
    logic        step;
    logic        loop_en;
    logic [30:0] datai;
    logic        obs;
    logic        issue;
    logic        busy;
    logic        done;
    logic [2:0]  pc;
    logic [15:0] issued_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    stim_seq dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .clear      (clear),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .loop_en    (loop_en),
        .datai      (datai),
        .obs        (obs),
        .issue      (issue),
        .busy       (busy),
        .done       (done),
        .pc         (pc),
        .issued_cnt (issued_cnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_data = '0; clear = 1'b0;
        start = 1'b0; stop = 1'b0; step = 1'b0; loop_en = 1'b0;
        tick(); tick();
        chk("rst_datai", datai, 0);
        chk("rst_obs", obs, 0);
        chk("rst_issue", issue, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pc", pc, 0);
        chk("rst_cnt", issued_cnt, 0);
        chk("rst_ready", load_ready, 1);
        reset = 1'b0;

        // Load and run three words.
        load(32'h8000_0001);
        load(32'h0000_0002);
        load(32'h7FFF_FFFF);
        start = 1'b1; tick(); start = 1'b0;
        chk("run_start_busy", busy, 1);
        chk("run_start_issue", issue, 0);
        tick();
        chk("run_w0", {issue, obs, datai}, {1'b1, 1'b1, 31'h1});
        chk("run_pc1", pc, 1);
        tick();
        chk("run_w1", {issue, obs, datai}, {1'b1, 1'b0, 31'h2});
        tick();
        chk("run_w2", {issue, obs, datai}, {1'b1, 1'b0, 31'h7FFF_FFFF});
        chk("run_done", done, 1);
        chk("run_cnt", issued_cnt, 3);
        chk("run_pc0", pc, 0);
        chk("run_busy0", busy, 0);
        tick();
        chk("done_hold", {issue, obs, datai}, {1'b0, 1'b0, 31'h7FFF_FFFF});

        // Full buffer: nine offers, only eight kept.
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_ready", load_ready, 1);
        chk("clr_done", done, 0);
        load_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            load_data = 32'h100 + i;
            tick();
        end
        load_valid = 1'b0;
        chk("full_ready", load_ready, 0);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("full_word", {issue, datai}, {1'b1, 31'h100 + 31'(i)});
        end
        chk("full_done", done, 1);
        chk("full_cnt", issued_cnt, 8);
        tick();
        chk("full_no9", issue, 0);

        // Pause and step.
        start = 1'b1; tick(); start = 1'b0;
        chk("ps_cnt0", issued_cnt, 0);
        tick();
        chk("ps_w0", {issue, datai}, {1'b1, 31'h100});
        stop = 1'b1; tick(); stop = 1'b0;
        chk("ps_stop", {issue, busy, datai}, {1'b0, 1'b1, 31'h100});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ps_idle", {issue, datai}, {1'b0, 31'h100});
        end
        step = 1'b1; tick(); step = 1'b0;
        chk("ps_step", {issue, datai}, {1'b1, 31'h101});
        tick();
        chk("ps_after_step", {issue, busy}, {1'b0, 1'b1});
        start = 1'b1; tick(); start = 1'b0;
        chk("ps_resume_edge", issue, 0);
        tick();
        chk("ps_w2", {issue, datai}, {1'b1, 31'h102});
        chk("ps_cnt3", issued_cnt, 3);

        // start+stop together while running -> pause.
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("ss_pause", {issue, busy}, {1'b0, 1'b1});
        tick();
        chk("ss_held", {issue, datai}, {1'b0, 31'h102});

        // clear outranks a load; an empty buffer ignores start.
        clear = 1'b1; tick();
        chk("cl_idle", {busy, done, pc}, 5'b0);
        load_valid = 1'b1; load_data = 32'hDEAD; tick();
        clear = 1'b0; load_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk("cl_empty_start", busy, 0);
        chk("cl_ready", load_ready, 1);

        // Loop over two entries.
        load(32'h0000_000A);
        load(32'h8000_000B);
        loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("lp_e0", {issue, obs, datai}, {1'b1, 1'b0, 31'hA});
        tick();
        chk("lp_e1", {issue, obs, datai}, {1'b1, 1'b1, 31'hB});
`ifdef STIM_SEQ_LOOP_EN
        chk("lp_busy1", {busy, pc}, {1'b1, 3'd0});
        tick();
        chk("lp_e2", {issue, busy, datai}, {1'b1, 1'b1, 31'hA});
        tick();
        chk("lp_e3", {issue, busy, datai}, {1'b1, 1'b1, 31'hB});
        tick();
        chk("lp_e4", {issue, busy, datai}, {1'b1, 1'b1, 31'hA});
`else
        chk("lp_done", {done, busy}, 2'b10);
        tick();
        chk("lp_stop", issue, 0);
`endif
        loop_en = 1'b0;

        // Reset in the middle of a run.
        clear = 1'b1; tick(); clear = 1'b0;
        load(32'h0000_0011);
        load(32'h0000_0022);
        load(32'h0000_0033);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("mr_w0", {issue, datai}, {1'b1, 31'h11});
        reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
        chk("mr_state", {busy, done, issue}, 3'b0);
        chk("mr_datai", datai, 0);
        chk("mr_cnt", issued_cnt, 0);
        chk("mr_pc", pc, 0);
        chk("mr_ready", load_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
